// File: rtl/lfsr_pattern_ctrl_if.sv
// Bus for the 3-bit LFSR pattern sequencer: board-side control/result signals plus the LFSR drive/observe lines.
// Optional port pattern_sig exists only when LFSR_PATTERN_SIG_EN is defined.
interface lfsr_pattern_ctrl_if #(
  parameter int WIDTH      = 3,
  parameter int MAX_CYCLES = 15
) ();
  localparam int CW = $clog2(MAX_CYCLES + 1);

  // start is only accepted while busy is low; done pulses once per accepted start,
  // and period/timeout/stuck/lfsr_tap_sel stay valid from that pulse until the next accept.
  logic             start;
  logic [WIDTH-1:0] tap_sel_in;
  logic [WIDTH-1:0] lfsr_out;
  logic             lfsr_clear;
  logic             lfsr_enable;
  logic [WIDTH-1:0] lfsr_tap_sel;
  logic             busy;
  logic             done;
  logic [CW-1:0]    period;
  logic             timeout;
  logic             stuck;
`ifdef LFSR_PATTERN_SIG_EN
  logic [WIDTH-1:0] pattern_sig;
`endif

  modport master (
    output start, tap_sel_in, lfsr_out,
`ifdef LFSR_PATTERN_SIG_EN
    input  pattern_sig,
`endif
    input  lfsr_clear, lfsr_enable, lfsr_tap_sel, busy, done, period, timeout, stuck
  );

  modport slave (
    input  start, tap_sel_in, lfsr_out,
`ifdef LFSR_PATTERN_SIG_EN
    output pattern_sig,
`endif
    output lfsr_clear, lfsr_enable, lfsr_tap_sel, busy, done, period, timeout, stuck
  );
endinterface

// File: rtl/lfsr_pattern_ctrl.sv
// Measures the period of the test-pattern LFSR for a latched tap selection, flagging timeout or a stuck pattern.
// Define LFSR_PATTERN_SIG_EN to add the XOR signature output pattern_sig.
module lfsr_pattern_ctrl #(
  parameter int WIDTH      = 3,
  parameter int MAX_CYCLES = 15
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_pattern_ctrl_if.slave  bus,
  output logic [2:0]          state_dbg
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MAX_STEPS = CW'(MAX_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tap_q, tap_d;
  logic [CW-1:0]    period_q, period_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic [WIDTH-1:0] start_val_q, start_val_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    steps_q, steps_d;
`ifdef LFSR_PATTERN_SIG_EN
  logic [WIDTH-1:0] sig_q, sig_d;
`endif

  logic lfsr_clear, lfsr_enable, done, busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      period_q    <= '0;
      timeout_q   <= 1'b0;
      stuck_q     <= 1'b0;
      start_val_q <= '0;
      prev_q      <= '0;
      steps_q     <= '0;
`ifdef LFSR_PATTERN_SIG_EN
      sig_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      period_q    <= period_d;
      timeout_q   <= timeout_d;
      stuck_q     <= stuck_d;
      start_val_q <= start_val_d;
      prev_q      <= prev_d;
      steps_q     <= steps_d;
`ifdef LFSR_PATTERN_SIG_EN
      sig_q       <= sig_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    period_d    = period_q;
    timeout_d   = timeout_q;
    stuck_d     = stuck_q;
    start_val_d = start_val_q;
    prev_d      = prev_q;
    steps_d     = steps_q;
`ifdef LFSR_PATTERN_SIG_EN
    sig_d       = sig_q;
`endif
    lfsr_clear  = 1'b0;
    lfsr_enable = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tap_d     = bus.tap_sel_in;
          period_d  = '0;
          timeout_d = 1'b0;
          stuck_d   = 1'b0;
`ifdef LFSR_PATTERN_SIG_EN
          sig_d     = '0;
`endif
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        lfsr_clear = 1'b1;
        state_d    = ARM;
      end
      ARM: begin
        // The cleared value seen here is the reference the pattern must return to.
        lfsr_enable = 1'b1;
        start_val_d = bus.lfsr_out;
        prev_d      = bus.lfsr_out;
        steps_d     = CW'(1);
`ifdef LFSR_PATTERN_SIG_EN
        sig_d       = bus.lfsr_out;
`endif
        state_d     = RUN;
      end
      RUN: begin
        lfsr_enable = 1'b1;
`ifdef LFSR_PATTERN_SIG_EN
        sig_d       = sig_q ^ bus.lfsr_out;
`endif
        // Stuck outranks a return to start so a fixed point never reports period 1.
        if (bus.lfsr_out == prev_q) begin
          stuck_d  = 1'b1;
          period_d = '0;
          state_d  = DONE;
        end else if (bus.lfsr_out == start_val_q) begin
          period_d = steps_q;
          state_d  = DONE;
        end else if (steps_q == MAX_STEPS) begin
          timeout_d = 1'b1;
          period_d  = '0;
          state_d   = DONE;
        end else begin
          prev_d  = bus.lfsr_out;
          steps_d = steps_q + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lfsr_clear   = lfsr_clear;
  assign bus.lfsr_enable  = lfsr_enable;
  assign bus.done         = done;
  assign bus.busy         = busy;
  assign bus.lfsr_tap_sel = tap_q;
  assign bus.period       = period_q;
  assign bus.timeout      = timeout_q;
  assign bus.stuck        = stuck_q;
`ifdef LFSR_PATTERN_SIG_EN
  assign bus.pattern_sig  = sig_q;
`endif
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_lfsr_pattern_ctrl.sv
// Bench for lfsr_pattern_ctrl: XNOR-feedback LFSR model on the bus, directed runs, expected-result queue.
module tb_lfsr_pattern_ctrl;
  localparam int WIDTH      = 3;
  localparam int MAX_CYCLES = 15;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef struct packed {
    logic [CW-1:0]    period;
    logic             timeout;
    logic             stuck;
    logic [WIDTH-1:0] tap;
    logic [WIDTH-1:0] sig;
    logic [7:0]       lat;
  } res_t;
  localparam int RW = $bits(res_t);

  logic clk = 1'b0;
  logic reset;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  lfsr_pattern_ctrl_if #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYCLES)) bus ();

  lfsr_pattern_ctrl #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [RW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  // LFSR under test: shift left, XNOR of tapped bits fed into bit 0.
  logic [WIDTH-1:0] lfsr_q = '0;
  bit               ovr_en = 1'b0;
  logic [WIDTH-1:0] ovr_val = '0;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] tap);
    return {q[WIDTH-2:0], ~(^(q & tap))};
  endfunction

  always @(posedge clk) begin
    if (bus.lfsr_clear) lfsr_q <= '0;
    else if (bus.lfsr_enable) lfsr_q <= lfsr_next(lfsr_q, bus.lfsr_tap_sel);
  end
  assign bus.lfsr_out = ovr_en ? ovr_val : lfsr_q;

  always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

  // Reference for randomly chosen taps: walk the pattern from the cleared state.
  function automatic res_t model_run(input logic [WIDTH-1:0] tap);
    res_t r;
    logic [WIDTH-1:0] q, first, prev;
    int steps;
    r = '0;
    r.tap = tap;
    q = '0; first = q; prev = q; r.sig = q; steps = 1;
    q = lfsr_next(q, tap);
    for (int n = 0; n <= MAX_CYCLES; n++) begin
      r.sig = r.sig ^ q;
      if (q == prev) begin r.stuck = 1'b1; break; end
      if (q == first) begin r.period = CW'(steps); break; end
      if (steps == MAX_CYCLES) begin r.timeout = 1'b1; break; end
      prev = q; steps++; q = lfsr_next(q, tap);
    end
    r.lat = 8'(steps + 3);
    return r;
  endfunction

  function automatic res_t mk(input int per, input bit to, input bit st, input logic [WIDTH-1:0] tap,
                              input logic [WIDTH-1:0] sig, input int lat);
    res_t r;
    r.period = CW'(per); r.timeout = to; r.stuck = st; r.tap = tap; r.sig = sig; r.lat = 8'(lat);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int run_base;

  task automatic do_run(input logic [WIDTH-1:0] tap, input res_t exp, input bit stuck_mode, input bit inject);
    int cyc, clr_cnt, en_cnt;
    bit busy_gap;
    res_t e;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.tap_sel_in = tap;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.tap_sel_in = WIDTH'($urandom_range(0, 7));
    run_base = done_cnt;
    cyc = 1; clr_cnt = 0; en_cnt = 0; busy_gap = 1'b0;
    @(negedge clk);
    chk("cleared_on_accept", {bus.period, bus.timeout, bus.stuck}, '0);
    while (cyc < 40) begin
      if (bus.done) break;
      if (!bus.busy) busy_gap = 1'b1;
      if (bus.lfsr_clear) clr_cnt++;
      if (bus.lfsr_enable) en_cnt++;
      if (inject && cyc == 5) begin bus.start = 1'b1; bus.tap_sel_in = 3'b110; end
      if (inject && cyc == 6) bus.start = 1'b0;
      @(posedge clk);
      cyc++;
      if (stuck_mode && cyc == 3) begin #1; ovr_val = '1; end
      @(negedge clk);
    end
    e = res_t'(exp_q.pop_front());
    chk("done_seen", bus.done, 1);
    chk("latency", cyc, e.lat);
    chk("busy_contig", busy_gap, 0);
    chk("busy_at_done", bus.busy, 1);
    chk("enable_at_done", bus.lfsr_enable, 0);
    chk("clear_count", clr_cnt, 1);
    chk("enable_count", en_cnt, e.lat - 2);
    chk("period", bus.period, e.period);
    chk("timeout", bus.timeout, e.timeout);
    chk("stuck", bus.stuck, e.stuck);
    chk("tap_sel", bus.lfsr_tap_sel, e.tap);
`ifdef LFSR_PATTERN_SIG_EN
    chk("pattern_sig", bus.pattern_sig, e.sig);
`endif
  endtask

  task automatic post_check(input res_t exp);
    @(negedge clk);
    chk("done_pulse_len", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    chk("state_idle", state_dbg, 0);
    chk("done_count", done_cnt - run_base, 1);
    chk("period_hold", bus.period, exp.period);
  endtask

  initial begin
    res_t r;
    logic [WIDTH-1:0] t;
    int d0;
    bus.start = 1'b0;
    bus.tap_sel_in = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_dbg, 0);
    chk("rst_outputs", {bus.lfsr_clear, bus.lfsr_enable, bus.lfsr_tap_sel, bus.busy, bus.done,
                        bus.period, bus.timeout, bus.stuck}, '0);
    reset = 1'b0;

    // Full 7-state pattern with taps 101.
    r = mk(7, 0, 0, 3'b101, 3'b111, 10);
    do_run(3'b101, r, 0, 0);
    post_check(r);

    // Taps 011 never return to 000.
    r = mk(0, 1, 0, 3'b011, 3'b111, 18);
    do_run(3'b011, r, 0, 0);
    post_check(r);

    // Reset during RUN aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.tap_sel_in = 3'b101;
    @(posedge clk); #1; bus.start = 1'b0;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_run", state_dbg, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", state_dbg, 0);
    chk("mid_rst_outputs", {bus.lfsr_clear, bus.lfsr_enable, bus.lfsr_tap_sel, bus.busy, bus.done,
                            bus.period, bus.timeout, bus.stuck}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_done_on_reset", done_cnt - d0, 0);

    // Clean run after reset, then start-while-busy attempt on a 101 run.
    r = mk(7, 0, 0, 3'b101, 3'b111, 10);
    do_run(3'b101, r, 0, 0);
    post_check(r);
    do_run(3'b101, r, 0, 1);
    post_check(r);

    // Forced stuck pattern: 000 through ARM, then 111.
    ovr_en = 1'b1; ovr_val = '0;
    r = mk(0, 0, 1, 3'b101, 3'b000, 5);
    do_run(3'b101, r, 1, 0);
    post_check(r);
    ovr_en = 1'b0;

    // Back-to-back: tap 000 (fixed point 111), then tap 110 on the cycle after done.
    r = mk(0, 0, 1, 3'b000, 3'b010, 7);
    do_run(3'b000, r, 0, 0);
    r = mk(7, 0, 0, 3'b110, 3'b111, 10);
    do_run(3'b110, r, 0, 0);
    post_check(r);

    for (int i = 0; i < 3; i++) begin
      t = WIDTH'($urandom_range(0, 7));
      r = model_run(t);
      do_run(t, r, 0, 0);
      post_check(r);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
